// File: rtl/decoder_scan_nto2n_if.sv
// Select bus between a display controller and the N-to-2^N scanning decoder.
// The controller drives en/mode/in; the decoder returns the registered select.
interface decoder_scan_nto2n_if #(
   parameter int N = 4
);
   logic            en;
   logic            mode;
   logic [N-1:0]    in;
   logic [2**N-1:0] bcode;
   logic [N-1:0]    idx;
   logic            tick;

   modport master (output en, mode, in, input bcode, idx, tick);
   modport slave  (input en, mode, in, output bcode, idx, tick);
endinterface

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N decoder with enable, selectable polarity and an auto-scan mode
// that steps the active select through 0..in once every PRESCALE clocks.
module decoder_scan_nto2n #(
   parameter int N          = 4,
   parameter int PRESCALE   = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input logic                 clk,
   input logic                 reset_n,
   decoder_scan_nto2n_if.slave bus
);

   localparam int W  = 2**N;
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            tick_q, tick_d;
   logic [W-1:0]    bcode_q, bcode_d;

   // Select pattern for one index; an idle decoder drives every bit inactive.
   function automatic logic [W-1:0] select_pattern(input logic [N-1:0] sel,
                                                   input logic         active);
      logic [W-1:0] oh;
      if (active) begin
         oh = {{(W-1){1'b0}}, 1'b1} << sel;
      end else begin
         oh = {W{1'b0}};
      end
      if (ACTIVE_LOW) begin
         return ~oh;
      end else begin
         return oh;
      end
   endfunction

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state depends only on en/mode, re-evaluated every edge.
   always_comb begin
      state_d = ST_IDLE;
      if (!bus.en) begin
         state_d = ST_IDLE;
      end else if (bus.mode) begin
         state_d = ST_SCAN;
      end else begin
         state_d = ST_DIRECT;
      end
   end

   // Output/datapath next values; scan entry always restarts at index 0.
   always_comb begin
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      case (state_d)
         ST_IDLE: begin
            idx_d = '0;
            cnt_d = '0;
         end
         ST_DIRECT: begin
            idx_d = bus.in;
            cnt_d = '0;
         end
         ST_SCAN: begin
            if (state_q != ST_SCAN) begin
               idx_d = '0;
               cnt_d = '0;
            end else if (cnt_q == CW'(PRESCALE - 1)) begin
               // in is sampled only here, so a shrunk range wraps instead of overrunning.
               cnt_d  = '0;
               tick_d = 1'b1;
               if (idx_q >= bus.in) begin
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + N'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            idx_d = '0;
            cnt_d = '0;
         end
      endcase
      bcode_d = select_pattern(idx_d, state_d != ST_IDLE);
   end

   // Output and prescaler registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q   <= '0;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         bcode_q <= select_pattern('0, 1'b0);
      end else begin
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         bcode_q <= bcode_d;
      end
   end

   assign bus.bcode = bcode_q;
   assign bus.idx   = idx_q;
   assign bus.tick  = tick_q;

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, monitors pop one per clock.
// Covers the default decoder (N=4, PRESCALE=4) and the N=1/PRESCALE=1/ACTIVE_LOW corner.
module tb_decoder_scan_nto2n;

   typedef struct packed {
      logic [15:0] bcode;
      logic [3:0]  idx;
      logic        tick;
      logic [79:0] name;
   } exp_t;

   typedef struct packed {
      logic [1:0]  bcode;
      logic        idx;
      logic        tick;
      logic [79:0] name;
   } cexp_t;

   logic   clk;
   logic   reset_n;
   int     checks;
   int     errors;
   exp_t   q[$];
   cexp_t  cq[$];

   decoder_scan_nto2n_if #(.N(4)) m_if();
   decoder_scan_nto2n_if #(.N(1)) c_if();

   decoder_scan_nto2n #(.N(4), .PRESCALE(4), .ACTIVE_LOW(1'b0)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (m_if)
   );

   decoder_scan_nto2n #(.N(1), .PRESCALE(1), .ACTIVE_LOW(1'b1)) u_corner (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (c_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within 100000 time units");
      $fatal(1, "watchdog expired");
   end

   // Main monitor: one expectation per clock whenever the scoreboard holds one.
   initial begin : mon_main
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (m_if.bcode !== e.bcode || m_if.idx !== e.idx || m_if.tick !== e.tick) begin
               errors++;
               $display("FAIL %0s: got bcode=%h idx=%0d tick=%b, want bcode=%h idx=%0d tick=%b",
                        e.name, m_if.bcode, m_if.idx, m_if.tick, e.bcode, e.idx, e.tick);
            end
         end
      end
   end

   initial begin : mon_corner
      cexp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (cq.size() > 0) begin
            e = cq.pop_front();
            checks++;
            if (c_if.bcode !== e.bcode || c_if.idx !== e.idx || c_if.tick !== e.tick) begin
               errors++;
               $display("FAIL %0s: got bcode=%b idx=%0d tick=%b, want bcode=%b idx=%0d tick=%b",
                        e.name, c_if.bcode, c_if.idx, c_if.tick, e.bcode, e.idx, e.tick);
            end
         end
      end
   end

   task automatic expect_next(input logic en_v, input logic mode_v, input logic [3:0] in_v,
                              input logic [15:0] b, input logic [3:0] x, input logic t,
                              input logic [79:0] nm);
      exp_t e;
      m_if.en   = en_v;
      m_if.mode = mode_v;
      m_if.in   = in_v;
      e.bcode = b;
      e.idx   = x;
      e.tick  = t;
      e.name  = nm;
      q.push_back(e);
   endtask

   task automatic step(input logic en_v, input logic mode_v, input logic [3:0] in_v,
                       input logic [15:0] b, input logic [3:0] x, input logic t,
                       input logic [79:0] nm);
      @(negedge clk);
      expect_next(en_v, mode_v, in_v, b, x, t, nm);
   endtask

   // Three idle prescale cycles holding prev, then the stepping cycle showing nxt.
   task automatic scan_step(input logic [3:0] in_v, input logic [3:0] prev,
                            input logic [3:0] nxt, input logic [79:0] nm);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, in_v, 16'h0001 << prev, prev, 1'b0, nm);
      end
      step(1'b1, 1'b1, in_v, 16'h0001 << nxt, nxt, 1'b1, nm);
   endtask

   task automatic cstep(input logic en_v, input logic mode_v, input logic in_v,
                        input logic [1:0] b, input logic x, input logic t,
                        input logic [79:0] nm);
      cexp_t e;
      @(negedge clk);
      c_if.en   = en_v;
      c_if.mode = mode_v;
      c_if.in   = in_v;
      e.bcode = b;
      e.idx   = x;
      e.tick  = t;
      e.name  = nm;
      cq.push_back(e);
   endtask

   task automatic check_reset_now(input logic [79:0] nm);
      checks++;
      if (m_if.bcode !== 16'h0000 || m_if.idx !== 4'd0 || m_if.tick !== 1'b0) begin
         errors++;
         $display("FAIL %0s: got bcode=%h idx=%0d tick=%b, want bcode=0000 idx=0 tick=0",
                  nm, m_if.bcode, m_if.idx, m_if.tick);
      end
      checks++;
      if (c_if.bcode !== 2'b11 || c_if.idx !== 1'b0 || c_if.tick !== 1'b0) begin
         errors++;
         $display("FAIL %0s_c: got bcode=%b idx=%0d tick=%b, want bcode=11 idx=0 tick=0",
                  nm, c_if.bcode, c_if.idx, c_if.tick);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset_n   = 1'b0;
      m_if.en   = 1'b0;
      m_if.mode = 1'b0;
      m_if.in   = 4'd0;
      c_if.en   = 1'b0;
      c_if.mode = 1'b0;
      c_if.in   = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // Asynchronous reset from a non-idle state, checked mid-cycle.
      step(1'b1, 1'b0, 4'd5, 16'h0020, 4'd5, 1'b0, "pre_rst");
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check_reset_now("rst_async");
      @(negedge clk);
      reset_n   = 1'b1;
      m_if.en   = 1'b0;

      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 4'(i), 16'h0001 << i, 4'(i), 1'b0, "direct");
      end
      step(1'b0, 1'b0, 4'd3, 16'h0000, 4'd0, 1'b0, "en_off");

      // Full scan including the 15 -> 0 wrap.
      step(1'b1, 1'b1, 4'd15, 16'h0001, 4'd0, 1'b0, "scan_in");
      for (int s = 1; s <= 16; s++) begin
         scan_step(4'd15, 4'(s - 1), (s == 16) ? 4'd0 : 4'(s), "scan_full");
      end

      // Narrow the range while idx=9.
      for (int s = 1; s <= 9; s++) begin
         scan_step(4'd15, 4'(s - 1), 4'(s), "scan_up");
      end
      scan_step(4'd3, 4'd9, 4'd0, "narrow");
      scan_step(4'd3, 4'd0, 4'd1, "narrow");
      scan_step(4'd3, 4'd1, 4'd2, "narrow");
      scan_step(4'd3, 4'd2, 4'd3, "narrow");
      scan_step(4'd3, 4'd3, 4'd0, "narrow");
      scan_step(4'd0, 4'd0, 4'd0, "in_zero");
      scan_step(4'd0, 4'd0, 4'd0, "in_zero");

      // Interrupts mid-scan.
      scan_step(4'd15, 4'd0, 4'd1, "pre_intr");
      step(1'b1, 1'b1, 4'd15, 16'h0002, 4'd1, 1'b0, "pre_intr");
      step(1'b1, 1'b1, 4'd15, 16'h0002, 4'd1, 1'b0, "pre_intr");
      step(1'b1, 1'b0, 4'd7, 16'h0080, 4'd7, 1'b0, "to_direct");
      step(1'b1, 1'b1, 4'd15, 16'h0001, 4'd0, 1'b0, "rescan");
      scan_step(4'd15, 4'd0, 4'd1, "rescan");
      step(1'b1, 1'b1, 4'd15, 16'h0002, 4'd1, 1'b0, "hold");
      step(1'b0, 1'b1, 4'd15, 16'h0000, 4'd0, 1'b0, "en_drop");
      step(1'b1, 1'b1, 4'd15, 16'h0001, 4'd0, 1'b0, "reen");
      scan_step(4'd15, 4'd0, 4'd1, "reen");
      scan_step(4'd15, 4'd1, 4'd2, "reen");

      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check_reset_now("rst_scan");
      @(negedge clk);
      reset_n = 1'b1;
      expect_next(1'b1, 1'b1, 4'd15, 16'h0001, 4'd0, 1'b0, "rst_entry");
      scan_step(4'd15, 4'd0, 4'd1, "rst_entry");

      // Corner instance: step every cycle, active-low, 1-bit select.
      cstep(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, "c_entry");
      cstep(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, "c_scan");
      cstep(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, "c_scan");
      cstep(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, "c_scan");
      cstep(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, "c_scan");
      cstep(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, "c_off");

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (q.size() != 0 || cq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", q.size(), cq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
